// File: rtl/alu_share_ctrl_if.sv
// Requester-side handshake bundle for the shared-ALU controller: one instance per requester.
interface alu_share_ctrl_if;
  logic        req_i;
  logic [2:0]  ctrl_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        gnt_o;
  logic        done_o;

  modport master (output req_i, ctrl_i, a_i, b_i, input gnt_o, done_o);
  modport slave  (input req_i, ctrl_i, a_i, b_i, output gnt_o, done_o);
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU between two requesters; operands are held
// for one cycle, or MUL_CYCLES cycles for multiply, then a registered result is returned.
module alu_share_ctrl #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  alu_share_ctrl_if.slave        rq0,
  alu_share_ctrl_if.slave        rq1,
  output logic [31:0]            alu_a_o,
  output logic [31:0]            alu_b_o,
  output logic [2:0]             alu_ctrl_o,
  input  logic [31:0]            alu_res_i,
  output logic [31:0]            result_o,
  output logic                   busy_o
);

  localparam logic [2:0] MUL_ALUCTRL = 3'b111;
  localparam logic [3:0] MUL_LOAD    = 4'(MUL_CYCLES);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] result_q, result_d;
  logic        gnt0, gnt1;
  logic [2:0]  sel_ctrl;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
    end
  end

  // Grants are gated by reset because the async reset only forces state, not req inputs.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    sel_ctrl = gnt1 ? rq1.ctrl_i : rq0.ctrl_i;
    unique case (state_q)
      IDLE: begin
        if (!rst_i) begin
          gnt0 = rq0.req_i && (!rq1.req_i || !ptr_q);
          gnt1 = rq1.req_i && (!rq0.req_i ||  ptr_q);
        end
        sel_ctrl = gnt1 ? rq1.ctrl_i : rq0.ctrl_i;
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          ptr_d   = gnt0;
          a_d     = gnt1 ? rq1.a_i : rq0.a_i;
          b_d     = gnt1 ? rq1.b_i : rq0.b_i;
          ctrl_d  = sel_ctrl;
          cnt_d   = (sel_ctrl == MUL_ALUCTRL) ? MUL_LOAD : 4'd1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd1) begin
          result_d = alu_res_i;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rq0.gnt_o  = gnt0;
  assign rq1.gnt_o  = gnt1;
  assign rq0.done_o = (state_q == DONE) && !owner_q;
  assign rq1.done_o = (state_q == DONE) &&  owner_q;
  assign busy_o     = (state_q != IDLE);
  assign alu_a_o    = a_q;
  assign alu_b_o    = b_q;
  assign alu_ctrl_o = ctrl_q;
  assign result_o   = result_q;

endmodule
